// File: rtl/shared_enc_io_ctrl.sv
// ---------------------------------------------------------------------------
// shared_enc_io_ctrl
//
// Handshake front-end and capture stage for a two-share masked 128-bit
// encryption core. A plaintext share pair is accepted on a valid/ready
// input and held stable on the core's plain inputs. The block then runs
// the core enable and captures the cipher share pair on the core's done
// pulse. The captured pair is presented on a valid/ready output. A
// run-length watchdog raises a sticky error if the core never completes.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake
//   in_share0 / in_share1      plaintext share pair
//   core_ena                   encryption core enable
//   core_plain0 / core_plain1  plaintext shares held for the core
//   core_cipher0 / 1           cipher shares from the core
//   core_done                  core completion pulse (cipher valid same cycle)
//   out_valid / out_ready      output handshake
//   out_share0 / out_share1    captured cipher share pair
//   busy                       high whenever the controller is not idle
//   err                        sticky watchdog error, cleared on next accept
//   rnd                        (SHARE_REFRESH_EN only) fresh re-mask value
//
// Optional feature macro: SHARE_REFRESH_EN
//   When defined, both cipher shares are XORed with rnd at capture. This
//   re-masks the result and leaves the unmasked value unchanged.
//
// Every output comes from a flop or is decoded from the state register, so
// no combinational path runs from any input to any output.
// ---------------------------------------------------------------------------
module shared_enc_io_ctrl #(
  parameter int DATA_W         = 128,
  parameter int MAX_RUN_CYCLES = 40,
  parameter int WD_W           = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_share0,
  input  logic [DATA_W-1:0] in_share1,
  output logic              core_ena,
  output logic [DATA_W-1:0] core_plain0,
  output logic [DATA_W-1:0] core_plain1,
  input  logic [DATA_W-1:0] core_cipher0,
  input  logic [DATA_W-1:0] core_cipher1,
  input  logic              core_done,
`ifdef SHARE_REFRESH_EN
  input  logic [DATA_W-1:0] rnd,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_share0,
  output logic [DATA_W-1:0] out_share1,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Last watchdog count before the run is abandoned. The counter starts at
  // zero on the first RUN cycle, so this gives MAX_RUN_CYCLES enabled cycles.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_RUN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] plain0_q, plain0_d;
  logic [DATA_W-1:0] plain1_q, plain1_d;
  logic [DATA_W-1:0] out0_q, out0_d;
  logic [DATA_W-1:0] out1_q, out1_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cap0, cap1;

  // The value captured from the core. With refresh enabled, the same random
  // mask goes onto both shares, so their XOR (the real cipher) is unchanged.
  // The two share paths are never combined with each other.
`ifdef SHARE_REFRESH_EN
  assign cap0 = core_cipher0 ^ rnd;
  assign cap1 = core_cipher1 ^ rnd;
`else
  assign cap0 = core_cipher0;
  assign cap1 = core_cipher1;
`endif

  // Next-state and datapath update. Inputs are sampled only in IDLE, so the
  // plain registers hold steady from PRIME until the next acceptance. A done
  // pulse is acted on only in RUN. If done arrives on the same cycle the
  // watchdog would fire, done takes priority.
  always_comb begin
    state_d  = state_q;
    plain0_d = plain0_q;
    plain1_d = plain1_q;
    out0_d   = out0_q;
    out1_d   = out1_q;
    wd_d     = wd_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          plain0_d = in_share0;
          plain1_d = in_share1;
          err_d    = 1'b0;
          wd_d     = '0;
          state_d  = ST_PRIME;
        end
      end
      ST_PRIME: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) begin
          out0_d  = cap0;
          out1_d  = cap1;
          state_d = ST_OUT;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is asynchronous, so core_ena and the
  // other decoded outputs drop as soon as rstn falls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      plain0_q <= '0;
      plain1_q <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      plain0_q <= plain0_d;
      plain1_q <= plain1_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign core_ena    = (state_q == ST_RUN);
  assign out_valid   = (state_q == ST_OUT);
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign core_plain0 = plain0_q;
  assign core_plain1 = plain1_q;
  assign out_share0  = out0_q;
  assign out_share1  = out1_q;

endmodule
